tt_um_wokwi_395355133883896833: RTL and testbench
=================================================

TT_UM_WOKWI_395355133883896833 -- requirements
Module: tt_um_wokwi_395355133883896833

Interface
REQ-001 SHALL have one clock and an asynchronous, active-low reset; the clock port is clk and the reset port is rst_n.
REQ-002 SHALL expose parameter LFSR_TAPS, default 8'hB8, the Galois LFSR feedback mask.
REQ-003 SHALL expose parameter RESET_VALUE, default 8'h00, the state register value on reset.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 ui_in  input  8  [0]=enable, [2:1]=mode, [3]=output select, [7:4]=data nibble.
REQ-007 uo_out  output  8  state or 7-segment/parity view, per REQ-016.
REQ-008 SHALL add no other RTL ports; vccd1/vssd1 power pins exist only in the gate-level netlist.

Function
REQ-009 SHALL hold one 8-bit state register S, updated only on rising clk when ui_in[0]=1; when ui_in[0]=0, S holds.
REQ-010 mode 2'b00 (UP): S <= S+1 mod 256; 8'hFF wraps to 8'h00.
REQ-011 mode 2'b01 (DOWN): S <= S-1 mod 256; 8'h00 wraps to 8'hFF.
REQ-012 mode 2'b10 (LFSR): S <= (S>>1) ^ (S[0] ? LFSR_TAPS : 8'h00).
REQ-013 LFSR lock-up: if S=8'h00 in LFSR mode, next S = 8'h01.
REQ-014 With default taps, the LFSR sequence has period 255.
REQ-015 mode 2'b11 (LOAD): S <= {S[3:0], ui_in[7:4]} (nibble shift-in); two LOAD cycles fully define S.
REQ-016 uo_out SHALL be purely combinational from S and ui_in[3]:
- ui_in[3]=0: uo_out = S.
- ui_in[3]=1: uo_out = {^S, SEG(S[3:0])}.
REQ-017 SEG SHALL be active-high, bit0=a .. bit6=g, with these codes:
- 0-7 = 3F,06,5B,4F,66,6D,7D,07.
- 8-F = 7F,6F,77,7C,39,5E,79,71.
REQ-018 Mode or enable changes SHALL take effect on the next rising edge; there is no pipeline and latency is exactly one cycle.
REQ-019 Changing ui_in[3] SHALL change uo_out in the same cycle without affecting S.

Reset
REQ-020 rst_n=0 SHALL immediately (asynchronously) set S=RESET_VALUE, regardless of clk or enable.
REQ-021 During reset, uo_out SHALL be 8'h00 when ui_in[3]=0 and 8'h3F when ui_in[3]=1 (default RESET_VALUE).
REQ-022 Reset deassertion SHALL be synchronous to clk; the first update occurs on the first rising edge after rst_n=1.
REQ-023 Reset asserted mid-LOAD SHALL discard any partially shifted nibble.

Structure
REQ-024 Shared package SHALL hold the mode encodings (MODE_UP, MODE_DOWN, MODE_LFSR, MODE_LOAD) and the 16-entry SEG table constant.
REQ-025 One sub-module, seg7_decoder (4-bit in, 7-bit out), SHALL implement SEG.
REQ-026 The next-state mux and LFSR logic SHALL live in the top module.

Verification
REQ-027 Reset, ui_in=8'h00 then 8'h08 -> uo_out 8'h00 then 8'h3F.
REQ-028 UP: load 8'hFE via LOAD nibbles F then E, then ui_in=8'h01 for 3 clocks -> uo_out FF, 00, 01.
REQ-029 DOWN from 8'h00, ui_in=8'h03, 2 clocks -> FF, FE.
REQ-030 LFSR from 8'h00, ui_in=8'h05, 3 clocks -> 01, B8, 5C; continuing, S returns to 01 after 255 further clocks.
REQ-031 LOAD nibble A then 5 (ui_in=8'hA7, 8'h57) -> S=8'hA5; ui_in[3]=1 -> uo_out 8'h6D (parity 0).
REQ-032 Enable=0 for 10 clocks in any mode -> S unchanged; then rst_n pulsed low between edges -> uo_out 8'h00 immediately.

Source files
------------

// File: rtl/tt_um_wokwi_395355133883896833_pkg.sv
// Shared definitions for the counter/LFSR/load block.
// Holds the mode encodings and the active-high seven-segment code table.
package tt_um_wokwi_395355133883896833_pkg;

    typedef enum logic [1:0] {
        MODE_UP   = 2'b00,
        MODE_DOWN = 2'b01,
        MODE_LFSR = 2'b10,
        MODE_LOAD = 2'b11
    } mode_e;

    // Segment bit0 = a .. bit6 = g; entry 15 is listed first (packed MSB).
    localparam logic [15:0][6:0] SEG_TABLE = {
        7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
        7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
    };

endpackage

// File: rtl/tt_um_wokwi_395355133883896833_seg7_decoder.sv
// Hex digit to active-high seven-segment pattern.
module seg7_decoder
    import tt_um_wokwi_395355133883896833_pkg::*;
(
    input  logic [3:0] digit_i,
    output logic [6:0] seg_o
);

    assign seg_o = SEG_TABLE[digit_i];

endmodule

// File: rtl/tt_um_wokwi_395355133883896833.sv
// 8-bit state register stepped as up/down counter, Galois LFSR or nibble
// shift register; output shows raw state or parity plus 7-segment digit.
module tt_um_wokwi_395355133883896833
    import tt_um_wokwi_395355133883896833_pkg::*;
#(
    parameter logic [7:0] LFSR_TAPS   = 8'hB8,
    parameter logic [7:0] RESET_VALUE = 8'h00
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] ui_in,
    output logic [7:0] uo_out
);

    logic       enable;
    mode_e      mode;
    logic       seg_sel;
    logic [3:0] nibble;

    logic [7:0] state_q;
    logic [7:0] state_d;
    logic [7:0] lfsr_next;
    logic [6:0] seg;

    assign enable  = ui_in[0];
    assign mode    = mode_e'(ui_in[2:1]);
    assign seg_sel = ui_in[3];
    assign nibble  = ui_in[7:4];

    // All-zero is the Galois lock-up state; kick it to 8'h01.
    assign lfsr_next = (state_q == 8'h00) ? 8'h01
                     : ({1'b0, state_q[7:1]} ^ (state_q[0] ? LFSR_TAPS : 8'h00));

    always_comb begin
        state_d = state_q;
        if (enable) begin
            unique case (mode)
                MODE_UP:   state_d = state_q + 8'd1;
                MODE_DOWN: state_d = state_q - 8'd1;
                MODE_LFSR: state_d = lfsr_next;
                MODE_LOAD: state_d = {state_q[3:0], nibble};
                default:   state_d = state_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RESET_VALUE;
        end else begin
            state_q <= state_d;
        end
    end

    seg7_decoder u_seg7_decoder (
        .digit_i (state_q[3:0]),
        .seg_o   (seg)
    );

    always_comb begin
        uo_out = state_q;
        if (seg_sel) begin
            uo_out = {^state_q, seg};
        end
    end

endmodule

// File: tb/tb_tt_um_wokwi_395355133883896833.sv
// Directed and randomized checks of tt_um_wokwi_395355133883896833 against
// an arithmetic reference model of the state register.
module tb_tt_um_wokwi_395355133883896833;

    logic       clk;
    logic       rst_n;
    logic [7:0] ui_in;
    logic [7:0] uo_out;

    int unsigned tests;
    int unsigned fails;
    logic [7:0]  s_m;

    logic [6:0] seg_ref [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    tt_um_wokwi_395355133883896833 dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .ui_in  (ui_in),
        .uo_out (uo_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] model_next(input logic [7:0] s, input logic [7:0] ui);
        int v;
        if (!ui[0]) return s;
        case (ui[2:1])
            2'd0: v = (int'(s) + 1) % 256;
            2'd1: v = (int'(s) + 255) % 256;
            2'd2: begin
                if (s == 8'h00) v = 1;
                else v = (int'(s) / 2) ^ ((int'(s) % 2 == 1) ? 'hB8 : 0);
            end
            default: v = (int'(s) % 16) * 16 + int'(ui[7:4]);
        endcase
        return 8'(v);
    endfunction

    function automatic logic [7:0] model_out(input logic [7:0] s, input logic sel);
        if (!sel) return s;
        return {1'($countones(s) % 2), seg_ref[s[3:0]]};
    endfunction

    task automatic check(input string tag, input logic [7:0] exp);
        tests++;
        assert (uo_out === exp)
        else begin
            fails++;
            $error("FAIL %s: uo_out=%h expected=%h", tag, uo_out, exp);
        end
    endtask

    task automatic step(input logic [7:0] ui, input string tag);
        ui_in = ui;
        @(posedge clk);
        #1;
        s_m = model_next(s_m, ui);
        check(tag, model_out(s_m, ui[3]));
    endtask

    task automatic view(input logic [7:0] ui, input string tag);
        ui_in = ui;
        #1;
        check(tag, model_out(s_m, ui[3]));
    endtask

    // Pulse reset between clock edges and check the output while it is held.
    task automatic pulse_reset(input string tag);
        #1;
        rst_n = 1'b0;
        #1;
        s_m = 8'h00;
        check(tag, model_out(s_m, ui_in[3]));
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        tests = 0;
        fails = 0;
        s_m   = 8'h00;
        rst_n = 1'b0;
        ui_in = 8'h00;
        #3;
        check("reset_raw", 8'h00);
        ui_in = 8'h08;
        #1;
        check("reset_seg", 8'h3F);
        @(negedge clk);
        rst_n = 1'b1;

        // UP across the wrap point
        step(8'hF7, "load_f");
        step(8'hE7, "load_e");
        check("load_fe", 8'hFE);
        step(8'h01, "up1");
        check("up_ff", 8'hFF);
        step(8'h01, "up2");
        check("up_wrap", 8'h00);
        step(8'h01, "up3");
        check("up_01", 8'h01);

        // DOWN from zero
        pulse_reset("rst_down");
        step(8'h03, "down1");
        check("down_ff", 8'hFF);
        step(8'h03, "down2");
        check("down_fe", 8'hFE);

        // LFSR lock-up escape and full period
        pulse_reset("rst_lfsr");
        step(8'h05, "lfsr1");
        check("lfsr_01", 8'h01);
        step(8'h05, "lfsr2");
        check("lfsr_b8", 8'hB8);
        step(8'h05, "lfsr3");
        check("lfsr_5c", 8'h5C);
        for (int i = 0; i < 253; i++) begin
            step(8'h05, "lfsr_run");
        end
        check("lfsr_period", 8'h01);

        // LOAD and display view
        step(8'hA7, "load_a");
        step(8'h57, "load_5");
        check("load_a5", 8'hA5);
        view(8'h08, "seg_a5");
        check("seg_6d", 8'h6D);
        view(8'h00, "raw_a5");
        check("raw_kept", 8'hA5);

        // Enable low holds in every mode
        for (int i = 0; i < 10; i++) begin
            step(8'($urandom) & 8'hF6, "hold");
        end
        view(8'h00, "hold_raw");
        check("hold_a5", 8'hA5);
        pulse_reset("rst_async");

        // Reset mid-LOAD discards the partial nibble
        step(8'hC7, "partial_c");
        pulse_reset("rst_midload");
        step(8'h37, "after_rst_3");
        check("midload_03", 8'h03);

        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(31) == 0) begin
                pulse_reset("rand_rst");
            end else begin
                step(8'($urandom), "rand_step");
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
